sw_input_avs: RTL and testbench

//  Avalon-MM responder that presents the board slide switches (Sw) to the Nios II.

---
 rtl/sw_input_avs.sv | 112 +++++++++++
 tb/tb_sw_input_avs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sw_input_avs.sv
// Avalon-MM responder for the board slide switches: two-flop synchroniser, per-bit debounce,
// sticky edge capture with write-1-to-clear, and a maskable level interrupt.
module sw_input_avs #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  Sw,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  logic [WIDTH-1:0] syncStage;
  logic [WIDTH-1:0] sw_s;
  logic [WIDTH-1:0] db;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] irqMask;
  logic [WIDTH-1:0] edgeCap;

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edgeSet;
  logic [WIDTH-1:0] w1cMask;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, writedata};

  // A bit is accepted on the edge its counter has seen DEBOUNCE_CYCLES-1 stable-different cycles
  always_comb begin
    accept  = '0;
    edgeSet = '0;
    w1cMask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sw_s[i] != db[i]) && (cnt[i] == CNT_MAX);
    end
    case (EDGE_MODE)
      0:       edgeSet = accept & sw_s;
      1:       edgeSet = accept & ~sw_s;
      default: edgeSet = accept;
    endcase
    if (write && (address == ADDR_EDGECAP)) begin
      w1cMask = writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      syncStage <= '0;
      sw_s      <= '0;
      db        <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      syncStage <= Sw;
      sw_s      <= syncStage;
      for (int i = 0; i < WIDTH; i++) begin
        if (sw_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= sw_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Set has priority over a same-cycle write-1-to-clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      irqMask <= '0;
      edgeCap <= '0;
    end else begin
      if (write && (address == ADDR_IRQMASK)) begin
        irqMask <= writedata[WIDTH-1:0];
      end
      edgeCap <= (edgeCap & ~w1cMask) | edgeSet;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        ADDR_DATA:    readdata <= 32'(db);
        ADDR_IRQMASK: readdata <= 32'(irqMask);
        ADDR_EDGECAP: readdata <= 32'(edgeCap);
        ADDR_RAW:     readdata <= 32'(sw_s);
        default:      readdata <= '0;
      endcase
    end
  end

  assign irq = |(edgeCap & irqMask);

endmodule

// File: tb/tb_sw_input_avs.sv
// Directed bench for sw_input_avs with a short debounce window (4 cycles) and both-edge capture.
module tb_sw_input_avs;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [WIDTH-1:0]  Sw;
  logic [1:0]        address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  int testCount = 0;
  int failCount = 0;
  logic [31:0] rdValue;

  sw_input_avs #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .EDGE_MODE(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Sw(Sw),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL timeout reached before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] swValue);
    Sw = swValue;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    data    = readdata;
  endtask

  initial begin
    RST = 1'b1; Sw = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    tick();
    tick();
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    RST = 1'b0;

    // Switches held high out of reset: DATA becomes visible to a read issued after edge 6
    applyStimulus(4'hF);
    address = 2'd0;
    read    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("powerup_data_e%0d", k), readdata, 32'h0);
    end
    tick();
    checkOutput("powerup_data_e7", readdata, 32'hF);
    read = 1'b0;
    busRead(2'd2, rdValue);
    checkOutput("powerup_edgecap", rdValue, 32'hF);
    checkOutput("powerup_irq_masked", {31'b0, irq}, 32'h0);
    busWrite(2'd2, 32'hF);
    busRead(2'd2, rdValue);
    checkOutput("w1c_all", rdValue, 32'h0);

    applyStimulus(4'h0);
    for (int k = 0; k < 8; k++) tick();
    busRead(2'd2, rdValue);
    checkOutput("falling_edgecap", rdValue, 32'hF);
    busWrite(2'd2, 32'hF);
    busRead(2'd0, rdValue);
    checkOutput("idle_data", rdValue, 32'h0);

    // Three-cycle glitch on Sw[0] shows on RAW but never reaches DATA
    applyStimulus(4'h1);
    address = 2'd3;
    read    = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("glitch_raw_high", readdata, 32'h1);
    applyStimulus(4'h0);
    tick();
    tick();
    tick();
    checkOutput("glitch_raw_low", readdata, 32'h0);
    read = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    busRead(2'd0, rdValue);
    checkOutput("glitch_data", rdValue, 32'h0);
    busRead(2'd2, rdValue);
    checkOutput("glitch_edgecap", rdValue, 32'h0);

    // Masked interrupt on Sw[1]
    busWrite(2'd1, 32'h2);
    applyStimulus(4'h2);
    for (int k = 1; k <= 5; k++) tick();
    checkOutput("irq_before_e6", {31'b0, irq}, 32'h0);
    tick();
    checkOutput("irq_at_e6", {31'b0, irq}, 32'h1);
    busRead(2'd2, rdValue);
    checkOutput("irq_edgecap", rdValue, 32'h2);
    busWrite(2'd2, 32'h2);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

    // W1C of bit 3 on the very edge bit 3 is accepted: set wins
    applyStimulus(4'hA);
    for (int k = 1; k <= 5; k++) tick();
    busWrite(2'd2, 32'h8);
    busRead(2'd2, rdValue);
    checkOutput("setwins_edgecap", rdValue, 32'h8);
    checkOutput("setwins_irq_unmasked", {31'b0, irq}, 32'h0);
    busWrite(2'd2, 32'h0);
    busRead(2'd2, rdValue);
    checkOutput("w1c_zero_keeps", rdValue, 32'h8);
    busWrite(2'd1, 32'h8);
    checkOutput("setwins_irq_masked", {31'b0, irq}, 32'h1);

    // DATA is read-only; readdata holds between reads
    busWrite(2'd0, 32'hDEAD);
    busRead(2'd0, rdValue);
    checkOutput("data_ro", rdValue, 32'hA);
    tick();
    checkOutput("readdata_hold", readdata, 32'hA);
    busRead(2'd1, rdValue);
    checkOutput("irqmask_read", rdValue, 32'h8);

    // Reset with Sw[2] mid-debounce (counter at 2) discards progress
    applyStimulus(4'hE);
    for (int k = 1; k <= 4; k++) tick();
    RST = 1'b1;
    tick();
    checkOutput("midreset_readdata", readdata, 32'h0);
    checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
    RST     = 1'b0;
    address = 2'd0;
    read    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("restart_data_e%0d", k), readdata, 32'h0);
    end
    tick();
    checkOutput("restart_data_e7", readdata, 32'hE);
    read = 1'b0;
    busRead(2'd2, rdValue);
    checkOutput("restart_edgecap", rdValue, 32'hE);
    busRead(2'd1, rdValue);
    checkOutput("restart_irqmask", rdValue, 32'h0);
    checkOutput("restart_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
